// File: rtl/seg7_pkg.sv
// seg7_pkg: segment constants, FSM state type and shared decoder (hex letters under SEG_DECODE_HEX_EN)
package seg7_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h1F;
    localparam logic [6:0] SEG_C = 7'h4E;
    localparam logic [6:0] SEG_D = 7'h3D;
    localparam logic [6:0] SEG_E = 7'h4F;
    localparam logic [6:0] SEG_F = 7'h47;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    typedef enum logic {S_TRACK, S_HOLD} state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] val;
    } dec_t;

    function automatic dec_t seg_decode(input logic [6:0] p);
        dec_t d;
        d = '{err: 1'b0, val: 4'h0};
        case (p)
            SEG_0: d.val = 4'h0;
            SEG_1: d.val = 4'h1;
            SEG_2: d.val = 4'h2;
            SEG_3: d.val = 4'h3;
            SEG_4: d.val = 4'h4;
            SEG_5: d.val = 4'h5;
            SEG_6: d.val = 4'h6;
            SEG_7: d.val = 4'h7;
            SEG_8: d.val = 4'h8;
            SEG_9: d.val = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            SEG_A: d.val = 4'hA;
            SEG_B: d.val = 4'hB;
            SEG_C: d.val = 4'hC;
            SEG_D: d.val = 4'hD;
            SEG_E: d.val = 4'hE;
            SEG_F: d.val = 4'hF;
`endif
            default: d.err = 1'b1;
        endcase
        return d;
    endfunction
endpackage

// File: rtl/seg_sync_filter.sv
// seg_sync_filter: 2-flop synchronizer on the segment bus plus a saturating stability counter
module seg_sync_filter #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [6:0] seg_raw,
    output logic [6:0] r_cand,
    output logic       stable
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [6:0]    sync1, sync2;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            r_cand <= '0;
            r_cnt  <= '0;
        end else begin
            sync1 <= seg_raw;
            sync2 <= sync1;
            if (sync2 != r_cand) begin
                r_cand <= sync2;
                r_cnt  <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign stable = r_cnt == CNT_MAX;
endmodule

// File: rtl/seven_seg_to_binary.sv
// seven_seg_to_binary: debounced 7-segment to 4-bit decoder with valid/ready output; SEG_DECODE_HEX_EN adds A-F
module seven_seg_to_binary
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Seg_a,
    input  logic       i_Seg_b,
    input  logic       i_Seg_c,
    input  logic       i_Seg_d,
    input  logic       i_Seg_e,
    input  logic       i_Seg_f,
    input  logic       i_Seg_g,
    input  logic       i_Ready,
    output logic [3:0] o_Binary,
    output logic       o_Error,
    output logic       o_Valid,
    output logic       o_Overrun
);
    logic [6:0] seg_raw, r_cand, r_last;
    logic       stable, accept, emit;
    state_t     state, state_d;
    dec_t       dec;

    assign seg_raw[SEG_A_BIT] = i_Seg_a;
    assign seg_raw[SEG_B_BIT] = i_Seg_b;
    assign seg_raw[SEG_C_BIT] = i_Seg_c;
    assign seg_raw[SEG_D_BIT] = i_Seg_d;
    assign seg_raw[SEG_E_BIT] = i_Seg_e;
    assign seg_raw[SEG_F_BIT] = i_Seg_f;
    assign seg_raw[SEG_G_BIT] = i_Seg_g;

    seg_sync_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .seg_raw (seg_raw),
        .r_cand  (r_cand),
        .stable  (stable)
    );

    // Leaving S_HOLD needs only the counter dropping, since any r_cand change zeroes it.
    always_comb begin
        state_d = stable ? S_HOLD : S_TRACK;
        accept  = state == S_TRACK && stable;
        emit    = accept && r_cand != r_last && r_cand != SEG_BLANK;
        dec     = seg_decode(r_cand);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= S_TRACK;
            r_last    <= SEG_BLANK;
            o_Valid   <= 1'b0;
            o_Binary  <= '0;
            o_Error   <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            state <= state_d;
            if (accept && r_cand != r_last)
                r_last <= r_cand;
            if (emit && (!o_Valid || i_Ready)) begin
                o_Valid  <= 1'b1;
                o_Binary <= dec.val;
                o_Error  <= dec.err;
            end else if (o_Valid && i_Ready) begin
                o_Valid <= 1'b0;
            end
            if (emit && o_Valid && !i_Ready)
                o_Overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seven_seg_to_binary.sv
// tb_seven_seg_to_binary: directed and random patterns checked against a run-length reference model
module tb_seven_seg_to_binary;
    localparam int S = 4;
    localparam logic [6:0] PAT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG_DECODE_HEX_EN
    localparam int NDIG = 16;
`else
    localparam int NDIG = 10;
`endif

    logic       i_Clk = 1'b0, i_Rst_n = 1'b0, i_Ready = 1'b1;
    logic       i_Seg_a, i_Seg_b, i_Seg_c, i_Seg_d, i_Seg_e, i_Seg_f, i_Seg_g;
    logic [3:0] o_Binary;
    logic       o_Error, o_Valid, o_Overrun;

    int         vectors = 0, miscompares = 0;
    logic [6:0] hist[$];
    logic [6:0] last = '0;
    logic       exp_valid = 1'b0, exp_err = 1'b0, exp_ovr = 1'b0;
    logic [3:0] exp_bin = '0;

    seven_seg_to_binary #(.STABLE_CYCLES(S)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n),
        .i_Seg_a(i_Seg_a), .i_Seg_b(i_Seg_b), .i_Seg_c(i_Seg_c), .i_Seg_d(i_Seg_d),
        .i_Seg_e(i_Seg_e), .i_Seg_f(i_Seg_f), .i_Seg_g(i_Seg_g),
        .i_Ready(i_Ready), .o_Binary(o_Binary), .o_Error(o_Error),
        .o_Valid(o_Valid), .o_Overrun(o_Overrun)
    );

    always #5 i_Clk = ~i_Clk;

    function automatic logic [6:0] h(input int i);
        return i < 0 ? 7'h00 : hist[i];
    endfunction

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < NDIG; i++)
            if (PAT[i] == p) return {1'b0, 4'(i)};
        return 5'b1_0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // A pattern is accepted once per run, S+2 edges after the run's first sample.
    task automatic model_edge(input logic [6:0] p, input logic r);
        int n, j;
        logic acc, emit;
        logic [6:0] c;
        logic [4:0] d;
        hist.push_back(p);
        n = hist.size() - 1;
        j = n - S - 2;
        acc = j >= 0 && h(j) != h(j - 1);
        for (int i = j; i <= n - 3 && acc; i++)
            if (h(i) != h(j)) acc = 1'b0;
        c = h(j);
        emit = acc && c != last && c != 7'h00;
        if (acc && c != last) last = c;
        if (emit) begin
            if (exp_valid && !r) exp_ovr = 1'b1;
            else begin
                d = ref_decode(c);
                exp_valid = 1'b1;
                exp_bin = d[3:0];
                exp_err = d[4];
            end
        end else if (exp_valid && r) exp_valid = 1'b0;
    endtask

    task automatic check_outputs();
        chk("valid", {3'b0, o_Valid}, {3'b0, exp_valid});
        chk("overrun", {3'b0, o_Overrun}, {3'b0, exp_ovr});
        if (exp_valid) begin
            chk("binary", o_Binary, exp_bin);
            chk("error", {3'b0, o_Error}, {3'b0, exp_err});
        end
    endtask

    task automatic step(input logic [6:0] p, input logic r);
        {i_Seg_a, i_Seg_b, i_Seg_c, i_Seg_d, i_Seg_e, i_Seg_f, i_Seg_g} = p;
        i_Ready = r;
        @(posedge i_Clk);
        model_edge(p, r);
        @(negedge i_Clk);
        check_outputs();
    endtask

    task automatic hold(input logic [6:0] p, input logic r, input int n);
        for (int i = 0; i < n; i++) step(p, r);
    endtask

    task automatic model_reset();
        hist.delete();
        last = '0;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        logic [6:0] p;
        {i_Seg_a, i_Seg_b, i_Seg_c, i_Seg_d, i_Seg_e, i_Seg_f, i_Seg_g} = 7'h00;
        repeat (2) @(negedge i_Clk);
        chk("rst_valid", {3'b0, o_Valid}, 4'h0);
        chk("rst_binary", o_Binary, 4'h0);
        chk("rst_error", {3'b0, o_Error}, 4'h0);
        chk("rst_overrun", {3'b0, o_Overrun}, 4'h0);
        i_Rst_n = 1'b1;
        model_reset();

        hold(7'h5B, 1'b1, 6);
        chk("single_early", {3'b0, o_Valid}, 4'h0);
        step(7'h5B, 1'b1);
        chk("single_valid", {3'b0, o_Valid}, 4'h1);
        chk("single_bin", o_Binary, 4'h5);
        chk("single_err", {3'b0, o_Error}, 4'h0);
        hold(7'h5B, 1'b1, 3);

        hold(7'h7E, 1'b1, 8);
        hold(7'h30, 1'b1, 3);
        hold(7'h7E, 1'b1, 10);

        hold(7'h79, 1'b1, 8);
        hold(7'h00, 1'b1, 8);
        hold(7'h79, 1'b1, 8);

        hold(7'h01, 1'b0, 8);
        chk("illegal_err", {3'b0, o_Error}, 4'h1);
        chk("illegal_bin", o_Binary, 4'h0);
        hold(7'h01, 1'b1, 2);
        hold(7'h77, 1'b0, 8);
`ifdef SEG_DECODE_HEX_EN
        chk("hex_a_bin", o_Binary, 4'hA);
        chk("hex_a_err", {3'b0, o_Error}, 4'h0);
`else
        chk("hex_a_bin", o_Binary, 4'h0);
        chk("hex_a_err", {3'b0, o_Error}, 4'h1);
`endif
        hold(7'h77, 1'b1, 2);

        hold(7'h30, 1'b0, 8);
        hold(7'h6D, 1'b0, 8);
        chk("ovr_bin", o_Binary, 4'h1);
        chk("ovr_flag", {3'b0, o_Overrun}, 4'h1);
        step(7'h6D, 1'b1);
        chk("ovr_drain", {3'b0, o_Valid}, 4'h0);
        chk("ovr_sticky", {3'b0, o_Overrun}, 4'h1);

        hold(7'h79, 1'b0, 8);
        chk("pre_rst_valid", {3'b0, o_Valid}, 4'h1);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("async_valid", {3'b0, o_Valid}, 4'h0);
        chk("async_binary", o_Binary, 4'h0);
        chk("async_error", {3'b0, o_Error}, 4'h0);
        chk("async_overrun", {3'b0, o_Overrun}, 4'h0);
        @(negedge i_Clk);
        i_Rst_n = 1'b1;
        model_reset();
        hold(7'h79, 1'b1, 10);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: p = 7'h00;
                1: p = 7'($urandom);
                default: p = PAT[$urandom_range(0, 15)];
            endcase
            for (int c = 0; c < int'($urandom_range(1, 8)); c++)
                step(p, $urandom_range(0, 3) != 0);
        end
        hold(7'h00, 1'b1, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
